// File: rtl/trap_seq_if.sv
// Core-side bundle of the trap/CSR-write sequencer: instruction and CSR read-back
// inputs in, CSR write port, stall and PC redirect out.
interface trap_seq_if;
  // There is no valid/ready pair: inst_valid qualifies ecall/mret/timer_irq for one
  // cycle, and the core must honour stall/redirect in the same cycle they are high.
  logic [31:0] pc;
  logic        inst_valid;
  logic        ecall;
  logic        mret;
  logic        inst_csr_we;
  logic [11:0] inst_csr_addr;
  logic [31:0] inst_csr_wdata;
  logic        timer_irq;
  logic [31:0] mstatus_q;
  logic [31:0] mtvec_q;
  logic [31:0] mepc_q;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        busy;

  modport master (
    output pc, inst_valid, ecall, mret, inst_csr_we, inst_csr_addr, inst_csr_wdata,
           timer_irq, mstatus_q, mtvec_q, mepc_q,
    input  csr_we, csr_waddr, csr_wdata, stall, redirect, redirect_pc, busy
  );

  modport slave (
    input  pc, inst_valid, ecall, mret, inst_csr_we, inst_csr_addr, inst_csr_wdata,
           timer_irq, mstatus_q, mtvec_q, mepc_q,
    output csr_we, csr_waddr, csr_wdata, stall, redirect, redirect_pc, busy
  );
endinterface

// File: rtl/trap_seq.sv
// Trap entry / mret sequencer that owns the CSR file write port: forwards instruction
// CSR writes when idle, otherwise writes mepc/mcause/mstatus one per cycle and redirects.
module trap_seq #(
  parameter logic [31:0] MTVEC_ALIGN_MASK = 32'hFFFF_FFFC,
  parameter logic [31:0] IRQ_CAUSE        = 32'h8000_0007,
  parameter logic [31:0] ECALL_CAUSE      = 32'd11
) (
  input  logic       clk,
  input  logic       rst,
  trap_seq_if.slave  bus,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_EPC   = 3'd1,
    W_CAUSE = 3'd2,
    W_STAT  = 3'd3,
    RESTORE = 3'd4,
    JUMP    = 3'd5
  } state_t;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  state_t      state_q, state_d;
  logic [31:0] epc_r, cause_r, stat_r, tgt_r;
  logic        irq_take, trap_take, mret_take;
  logic [31:0] stat_entry, stat_exit;

  logic        we_c, stall_c, redirect_c;
  logic [11:0] waddr_c;
  logic [31:0] wdata_c, rpc_c;

  assign irq_take  = bus.inst_valid & bus.timer_irq & bus.mstatus_q[3];
  assign trap_take = irq_take | (bus.inst_valid & bus.ecall);
  assign mret_take = bus.inst_valid & bus.mret & ~irq_take;

  // Entry: MPIE <- MIE, MIE <- 0. Exit: MIE <- MPIE, MPIE <- 1.
  assign stat_entry = {stat_r[31:8], stat_r[3], stat_r[6:4], 1'b0, stat_r[2:0]};
  assign stat_exit  = {stat_r[31:8], 1'b1, stat_r[6:4], stat_r[7], stat_r[2:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      epc_r   <= '0;
      cause_r <= '0;
      stat_r  <= '0;
      tgt_r   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && trap_take) begin
        epc_r   <= bus.pc;
        cause_r <= irq_take ? IRQ_CAUSE : ECALL_CAUSE;
        stat_r  <= bus.mstatus_q;
      end else if (state_q == IDLE && mret_take) begin
        stat_r  <= bus.mstatus_q;
        tgt_r   <= bus.mepc_q;
      end else if (state_q == W_STAT) begin
        tgt_r   <= bus.mtvec_q & MTVEC_ALIGN_MASK;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    we_c       = 1'b0;
    waddr_c    = '0;
    wdata_c    = '0;
    stall_c    = 1'b0;
    redirect_c = 1'b0;
    rpc_c      = '0;
    case (state_q)
      IDLE: begin
        if (trap_take) begin
          stall_c = 1'b1;
          state_d = W_EPC;
        end else if (mret_take) begin
          stall_c = 1'b1;
          state_d = RESTORE;
        end else begin
          we_c    = bus.inst_csr_we;
          waddr_c = bus.inst_csr_addr;
          wdata_c = bus.inst_csr_wdata;
        end
      end
      W_EPC: begin
        we_c    = 1'b1;
        waddr_c = ADDR_MEPC;
        wdata_c = epc_r;
        stall_c = 1'b1;
        state_d = W_CAUSE;
      end
      W_CAUSE: begin
        we_c    = 1'b1;
        waddr_c = ADDR_MCAUSE;
        wdata_c = cause_r;
        stall_c = 1'b1;
        state_d = W_STAT;
      end
      W_STAT: begin
        we_c    = 1'b1;
        waddr_c = ADDR_MSTATUS;
        wdata_c = stat_entry;
        stall_c = 1'b1;
        state_d = JUMP;
      end
      RESTORE: begin
        we_c    = 1'b1;
        waddr_c = ADDR_MSTATUS;
        wdata_c = stat_exit;
        stall_c = 1'b1;
        state_d = JUMP;
      end
      JUMP: begin
        redirect_c = 1'b1;
        rpc_c      = tgt_r;
        stall_c    = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A reset cycle silences every output, even if the state register is mid-sequence.
    if (rst) begin
      state_d    = IDLE;
      we_c       = 1'b0;
      waddr_c    = '0;
      wdata_c    = '0;
      stall_c    = 1'b0;
      redirect_c = 1'b0;
      rpc_c      = '0;
    end
  end

  assign bus.csr_we      = we_c;
  assign bus.csr_waddr   = waddr_c;
  assign bus.csr_wdata   = wdata_c;
  assign bus.stall       = stall_c;
  assign bus.redirect    = redirect_c;
  assign bus.redirect_pc = rpc_c;
  assign bus.busy        = (state_q != IDLE) & ~rst;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_trap_seq.sv
// Directed bench for trap_seq: a transaction-level model predicts every cycle's
// outputs, and literal checks pin the hand-computed sequences.
module tb_trap_seq;
  localparam logic [31:0] MASK  = 32'hFFFF_FFFC;
  localparam logic [31:0] IRQC  = 32'h8000_0007;
  localparam logic [31:0] ECALC = 32'd11;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;
  int         n_cmp;
  int         n_err;

  trap_seq_if bus ();

  trap_seq #(
    .MTVEC_ALIGN_MASK(MASK),
    .IRQ_CAUSE       (IRQC),
    .ECALL_CAUSE     (ECALC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .state_dbg(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model + scoreboard ----------------
  // Entry packing: {jump, latch_mtvec, we, addr[11:0], data[31:0]}
  logic [46:0] exp_q[$];
  logic [31:0] m_tgt;

  always @(negedge clk) begin
    logic [46:0] e;
    logic        irq;
    logic [31:0] st;
    logic        x_we, x_stall, x_redir, x_busy;
    logic [11:0] x_addr;
    logic [31:0] x_data, x_rpc;
    x_we = 1'b0; x_stall = 1'b0; x_redir = 1'b0; x_busy = 1'b0;
    x_addr = '0; x_data = '0; x_rpc = '0;
    if (rst) begin
      exp_q.delete();
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      x_busy  = 1'b1;
      x_stall = 1'b1;
      if (e[45]) m_tgt = bus.mtvec_q & MASK;
      x_we   = e[44];
      x_addr = e[43:32];
      x_data = e[31:0];
      if (e[46]) begin
        x_redir = 1'b1;
        x_rpc   = m_tgt;
      end
    end else begin
      irq = bus.inst_valid & bus.timer_irq & bus.mstatus_q[3];
      if (irq || (bus.inst_valid && bus.ecall)) begin
        x_stall = 1'b1;
        st = bus.mstatus_q;
        st[7] = st[3];
        st[3] = 1'b0;
        exp_q.push_back({2'b00, 1'b1, 12'h341, bus.pc});
        exp_q.push_back({2'b00, 1'b1, 12'h342, irq ? IRQC : ECALC});
        exp_q.push_back({2'b01, 1'b1, 12'h300, st});
        exp_q.push_back({2'b10, 1'b0, 12'h000, 32'h0});
      end else if (bus.inst_valid && bus.mret) begin
        x_stall = 1'b1;
        m_tgt = bus.mepc_q;
        st = bus.mstatus_q;
        st[3] = st[7];
        st[7] = 1'b1;
        exp_q.push_back({2'b00, 1'b1, 12'h300, st});
        exp_q.push_back({2'b10, 1'b0, 12'h000, 32'h0});
      end else begin
        x_we   = bus.inst_csr_we;
        x_addr = bus.inst_csr_addr;
        x_data = bus.inst_csr_wdata;
      end
    end
    n_cmp++;
    if (bus.csr_we !== x_we || (x_we && (bus.csr_waddr !== x_addr || bus.csr_wdata !== x_data))
        || bus.stall !== x_stall || bus.redirect !== x_redir || bus.busy !== x_busy
        || ((x_redir || rst) && bus.redirect_pc !== x_rpc)) begin
      n_err++;
      $display("FAIL model t=%0t st=%0d: got we=%b %h=%h stall=%b redir=%b rpc=%h busy=%b, want we=%b %h=%h stall=%b redir=%b rpc=%h busy=%b",
               $time, dbg_state, bus.csr_we, bus.csr_waddr, bus.csr_wdata, bus.stall, bus.redirect,
               bus.redirect_pc, bus.busy, x_we, x_addr, x_data, x_stall, x_redir, x_rpc, x_busy);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_in();
    bus.pc = 32'h8000_0000; bus.inst_valid = 1'b1; bus.ecall = 1'b0; bus.mret = 1'b0;
    bus.inst_csr_we = 1'b0; bus.inst_csr_addr = 12'h000; bus.inst_csr_wdata = 32'h0;
    bus.timer_irq = 1'b0; bus.mstatus_q = 32'h0; bus.mtvec_q = 32'h8000_0100;
    bus.mepc_q = 32'h0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic we, input logic [11:0] a,
                     input logic [31:0] d, input logic st, input logic rd,
                     input logic [31:0] rpc);
    @(negedge clk);
    n_cmp++;
    if (bus.csr_we !== we || (we && (bus.csr_waddr !== a || bus.csr_wdata !== d))
        || bus.stall !== st || bus.redirect !== rd || ((rd || rst) && bus.redirect_pc !== rpc)) begin
      n_err++;
      $display("FAIL %s: got we=%b %h=%h stall=%b redir=%b rpc=%h, want we=%b %h=%h stall=%b redir=%b rpc=%h",
               name, bus.csr_we, bus.csr_waddr, bus.csr_wdata, bus.stall, bus.redirect,
               bus.redirect_pc, we, a, d, st, rd, rpc);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    m_tgt = '0;
    rst = 1'b1;
    idle_in();
    bus.ecall = 1'b1;
    lit("reset", 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    next_cycle(); rst = 1'b0; idle_in();

    // csrrw pass-through
    bus.inst_csr_we = 1'b1; bus.inst_csr_addr = 12'h305; bus.inst_csr_wdata = 32'h8000_0100;
    lit("csrrw", 1'b1, 12'h305, 32'h8000_0100, 1'b0, 1'b0, 32'h0);

    // ecall without inst_valid is not taken
    next_cycle(); idle_in(); bus.inst_valid = 1'b0; bus.ecall = 1'b1;
    lit("ecall_invalid", 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0);

    // ecall trap entry
    next_cycle(); idle_in(); bus.ecall = 1'b1; bus.pc = 32'h8000_0040;
    bus.mstatus_q = 32'h8; bus.mtvec_q = 32'h8000_0203;
    lit("ecall_T", 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    next_cycle(); bus.ecall = 1'b0;
    lit("ecall_mepc", 1'b1, 12'h341, 32'h8000_0040, 1'b1, 1'b0, 32'h0);
    next_cycle();
    lit("ecall_mcause", 1'b1, 12'h342, 32'h0000_000B, 1'b1, 1'b0, 32'h0);
    next_cycle();
    lit("ecall_mstatus", 1'b1, 12'h300, 32'h0000_0080, 1'b1, 1'b0, 32'h0);
    next_cycle();
    lit("ecall_jump", 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 32'h8000_0200);

    // mret immediately after JUMP
    next_cycle(); bus.mret = 1'b1; bus.mstatus_q = 32'h80; bus.mepc_q = 32'h8000_0044;
    lit("mret_T", 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    next_cycle(); bus.mret = 1'b0;
    lit("mret_mstatus", 1'b1, 12'h300, 32'h0000_0088, 1'b1, 1'b0, 32'h0);
    next_cycle();
    lit("mret_jump", 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 32'h8000_0044);
    next_cycle();
    lit("mret_after", 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0);

    // interrupt beats ecall and drops its CSR write; irq pulses and busy-time ecall ignored
    next_cycle(); idle_in(); bus.ecall = 1'b1; bus.timer_irq = 1'b1; bus.mstatus_q = 32'h8;
    bus.pc = 32'h8000_1000; bus.inst_csr_we = 1'b1; bus.inst_csr_addr = 12'h305;
    bus.inst_csr_wdata = 32'h1234_5678;
    lit("irq_T", 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    next_cycle(); bus.timer_irq = 1'b0;
    lit("irq_mepc", 1'b1, 12'h341, 32'h8000_1000, 1'b1, 1'b0, 32'h0);
    next_cycle(); bus.timer_irq = 1'b1;
    lit("irq_mcause", 1'b1, 12'h342, 32'h8000_0007, 1'b1, 1'b0, 32'h0);
    next_cycle(); bus.timer_irq = 1'b0;
    lit("irq_mstatus", 1'b1, 12'h300, 32'h0000_0080, 1'b1, 1'b0, 32'h0);
    next_cycle(); bus.ecall = 1'b0; bus.inst_csr_we = 1'b0;
    lit("irq_jump", 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 32'h8000_0100);

    // MIE clear: same stimulus takes the ecall path; other mstatus bits pass through
    next_cycle(); bus.ecall = 1'b1; bus.timer_irq = 1'b1; bus.mstatus_q = 32'h1800;
    bus.pc = 32'h8000_2000; bus.inst_csr_we = 1'b1;
    lit("mie0_T", 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    next_cycle(); bus.ecall = 1'b0; bus.timer_irq = 1'b0; bus.inst_csr_we = 1'b0;
    lit("mie0_mepc", 1'b1, 12'h341, 32'h8000_2000, 1'b1, 1'b0, 32'h0);
    next_cycle();
    lit("mie0_mcause", 1'b1, 12'h342, 32'h0000_000B, 1'b1, 1'b0, 32'h0);
    next_cycle();
    lit("mie0_mstatus", 1'b1, 12'h300, 32'h0000_1800, 1'b1, 1'b0, 32'h0);
    next_cycle();
    lit("mie0_jump", 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 32'h8000_0100);

    // reset while writing mcause aborts the sequence
    next_cycle(); idle_in(); bus.ecall = 1'b1; bus.pc = 32'h8000_3000; bus.mstatus_q = 32'h8;
    lit("rst_T", 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    next_cycle(); bus.ecall = 1'b0;
    lit("rst_mepc", 1'b1, 12'h341, 32'h8000_3000, 1'b1, 1'b0, 32'h0);
    next_cycle(); rst = 1'b1;
    lit("rst_mid", 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_busy: got %b, want 0", bus.busy);
    end
    next_cycle(); rst = 1'b0;
    lit("rst_after", 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    next_cycle(); bus.inst_csr_we = 1'b1; bus.inst_csr_addr = 12'h305;
    bus.inst_csr_wdata = 32'hCAFE_0000;
    lit("csrrw_after_rst", 1'b1, 12'h305, 32'hCAFE_0000, 1'b0, 1'b0, 32'h0);

    next_cycle(); idle_in();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
